prefetch_queue: RTL and testbench
=================================

PREFETCH_QUEUE -- requirements
Module: prefetch_queue

Interface
REQ-001 Parameter ADDR_SIZE, default 32, sets the byte-address width.
REQ-002 Parameter QBYTES, default 8, sets the byte queue depth; must be a power of two, at least 8.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 strb  input  1  decoder byte request, held until mfc is seen.
REQ-006 addr  input  ADDR_SIZE  requested byte address, valid while strb=1.
REQ-007 mfc  output  1  memory-function-complete; data valid while high.
REQ-008 data  output  8  requested byte.
REQ-009 mem_req  output  1  word fetch request to memory.
REQ-010 mem_addr  output  ADDR_SIZE  word-aligned fetch address (bits [1:0]=0).
REQ-011 mem_ack  input  1  one-cycle pulse; mem_data valid in that cycle.
REQ-012 mem_data  input  32  fetched word, little-endian (byte 0 = bits [7:0]).

Function
REQ-013 The block keeps a circular byte queue holding consecutive bytes from head address qaddr, with occupancy count 0..QBYTES.
REQ-014 Fetch FSM states are F_IDLE, F_REQ and F_DROP.
REQ-015 F_IDLE->F_REQ when free space >= 4 bytes and a fetch target is known; the block drives mem_req=1 and mem_addr=fetch_ptr&~3 throughout F_REQ.
REQ-016 On mem_ack in F_REQ, the block pushes bytes fetch_ptr[1:0]..3 of mem_data, advances fetch_ptr to the next word boundary, and returns to F_IDLE.
REQ-017 Serve FSM states are S_WAIT and S_HOLD.
REQ-018 In S_WAIT with strb=1, addr==qaddr and count>0: data=head byte, pop, qaddr+1, mfc=1 from the next cycle, go to S_HOLD.
REQ-019 The block holds mfc and data stable in S_HOLD until strb=0, then drops mfc in the following cycle and returns to S_WAIT (four-phase handshake).
REQ-020 In S_WAIT with strb=1 and addr!=qaddr (jump or first access): flush the queue, set qaddr=fetch_ptr=addr, count=0; if in F_REQ, go to F_DROP.
REQ-021 In F_DROP the block keeps mem_req=1 until mem_ack, discards that word, and then refetches from the new fetch_ptr; a memory transaction is never abandoned mid-flight.
REQ-022 Minimum latency is 1 cycle from strb to mfc on a queue hit.
REQ-023 On a miss, mfc asserts 1 cycle after the first mem_ack carrying the addressed byte.
REQ-024 If a push and a pop occur in the same cycle, count changes by (pushed - 1).
REQ-025 Count shall never exceed QBYTES; the fetch gating of REQ-015 guarantees this.
REQ-026 Address arithmetic wraps modulo 2^ADDR_SIZE; a fetch at the top word continues at address 0.
REQ-027 Before the first strb the fetch target is unknown and no fetch is issued.

Reset
REQ-028 On reset, without waiting for clk: mfc=0, data=0, mem_req=0, mem_addr=0, count=0, qaddr=0, fetch_ptr=0, target-known=0, states F_IDLE and S_WAIT.
REQ-029 A reset during F_REQ abandons the request; after release, any stale mem_ack arriving in F_IDLE is ignored.

Configuration
REQ-030 With PREFETCH_QUEUE_STATS_EN defined, the block adds 32-bit outputs hit_cnt (strb served without a flush) and flush_cnt (REQ-020 events), both saturating and cleared by reset.
REQ-031 Without PREFETCH_QUEUE_STATS_EN, these ports and counters do not exist and behaviour is otherwise identical.

Structure
REQ-032 A shared package pfq_pkg holds the fetch and serve state encodings and the default ADDR_SIZE and QBYTES constants.
REQ-033 The byte storage with its push/pop pointers forms one sub-module, pfq_byte_fifo, which accepts 1-4 byte pushes and single-byte pops.

Verification
REQ-034 Reset, then strb with addr=0x100 and memory returning 0x44332211 after 2 cycles -> mem_addr=0x100; mfc with data=0x11; the next three sequential strb get 0x22, 0x33, 0x44 with 1-cycle latency each.
REQ-035 First strb at addr=0x103 -> fetch 0x100, only byte 3 queued, data=byte[31:24]; the next fetch is at 0x104.
REQ-036 Flush while in F_REQ: strb addr=0x200 during an outstanding fetch of 0x108 -> ack for 0x108 discarded, then mem_addr=0x200, served byte comes from 0x200.
REQ-037 Decoder stalls with strb=0 while fetches continue -> count saturates at 8, mem_req stays 0, no data lost; subsequent bytes are served in order.
REQ-038 strb held high 5 cycles after mfc -> mfc and data stable until strb=0; mfc=0 one cycle later.
REQ-039 Reset asserted mid-F_REQ -> mem_req=0 immediately, a stale mem_ack after release is ignored, and with PREFETCH_QUEUE_STATS_EN defined hit_cnt=flush_cnt=0.

Source files
------------

// File: rtl/pfq_pkg.sv
// rtl/pfq_pkg.sv - shared state encodings and defaults for the prefetch queue
package pfq_pkg;

    localparam int PFQ_ADDR_SIZE = 32;
    localparam int PFQ_QBYTES    = 8;

    localparam logic [1:0] F_IDLE = 2'd0;
    localparam logic [1:0] F_REQ  = 2'd1;
    localparam logic [1:0] F_DROP = 2'd2;

    localparam logic S_WAIT = 1'b0;
    localparam logic S_HOLD = 1'b1;

    // A fetch starting mid-word only yields the bytes from the offset up to the word end.
    function automatic logic [2:0] push_bytes(input logic [1:0] offset);
        return 3'd4 - {1'b0, offset};
    endfunction

endpackage

// File: rtl/pfq_byte_fifo.sv
// rtl/pfq_byte_fifo.sv - circular byte store taking 1-4 byte pushes and single-byte pops
module pfq_byte_fifo
    import pfq_pkg::*;
#(
    parameter int QBYTES = PFQ_QBYTES
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      flush,
    input  logic [2:0]                push_n,
    input  logic [31:0]               push_data,
    input  logic                      pop,
    output logic [7:0]                head,
    output logic [$clog2(QBYTES):0]   count
);

    localparam int PW = $clog2(QBYTES);
    localparam int CW = PW + 1;

    logic [7:0]    mem [QBYTES];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;

    assign head = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!flush) begin
            for (int i = 0; i < 4; i++) begin
                if (3'(i) < push_n) begin
                    mem[wr_ptr + PW'(i)] <= push_data[8*i +: 8];
                end
            end
        end
    end

    // A pop on an empty store is legal when a push lands in the same cycle;
    // the caller takes that byte straight from push_data.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + PW'(push_n);
            rd_ptr <= rd_ptr + PW'(pop);
            count  <= count + CW'(push_n) - CW'(pop);
        end
    end

endmodule

// File: rtl/prefetch_queue.sv
// rtl/prefetch_queue.sv - byte prefetch queue between a decoder and word memory; PREFETCH_QUEUE_STATS_EN adds hit/flush counters
module prefetch_queue
    import pfq_pkg::*;
#(
    parameter int ADDR_SIZE = PFQ_ADDR_SIZE,
    parameter int QBYTES    = PFQ_QBYTES
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 strb,
    input  logic [ADDR_SIZE-1:0] addr,
    output logic                 mfc,
    output logic [7:0]           data,
    output logic                 mem_req,
    output logic [ADDR_SIZE-1:0] mem_addr,
    input  logic                 mem_ack,
    input  logic [31:0]          mem_data
`ifdef PREFETCH_QUEUE_STATS_EN
    ,
    output logic [31:0]          hit_cnt,
    output logic [31:0]          flush_cnt
`endif
);

    localparam int CW = $clog2(QBYTES) + 1;

    logic [1:0]           fstate;
    logic                 sstate;
    logic [ADDR_SIZE-1:0] fetch_ptr;
    logic [ADDR_SIZE-1:0] qaddr;
    logic [ADDR_SIZE-1:0] req_addr;
    logic                 target_known;

    logic [CW-1:0]        count;
    logic [7:0]           fifo_head;
    logic                 flush;
    logic                 push_valid;
    logic [2:0]           push_n;
    logic [31:0]          push_data;
    logic                 serve;
    logic [7:0]           serve_byte;
    logic                 room;
    logic [ADDR_SIZE-1:0] next_word;

    // fetch_ptr always equals qaddr + count, so an empty queue's next byte is
    // the first byte of whatever word is being pushed.
    always_comb begin
        flush      = (sstate == S_WAIT) && strb && (!target_known || (addr != qaddr));
        push_valid = (fstate == F_REQ) && mem_ack && !flush;
        push_n     = push_valid ? push_bytes(fetch_ptr[1:0]) : 3'd0;
        push_data  = mem_data >> {fetch_ptr[1:0], 3'b000};
        serve      = (sstate == S_WAIT) && strb && target_known && (addr == qaddr)
                     && ((count != '0) || push_valid);
        serve_byte = (count != '0) ? fifo_head : push_data[7:0];
        room       = (count <= CW'(QBYTES - 4));
        next_word  = {fetch_ptr[ADDR_SIZE-1:2] + 1'b1, 2'b00};
    end

    assign mem_req  = (fstate != F_IDLE);
    assign mem_addr = req_addr;

    pfq_byte_fifo #(
        .QBYTES (QBYTES)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .push_n    (push_n),
        .push_data (push_data),
        .pop       (serve),
        .head      (fifo_head),
        .count     (count)
    );

    // An in-flight memory word is never abandoned: a jump during F_REQ waits
    // in F_DROP for the ack and throws that word away.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fstate       <= F_IDLE;
            req_addr     <= '0;
            fetch_ptr    <= '0;
            target_known <= 1'b0;
        end else begin
            if (flush) begin
                fetch_ptr    <= addr;
                target_known <= 1'b1;
            end else if (push_valid) begin
                fetch_ptr <= next_word;
            end

            case (fstate)
                F_IDLE: begin
                    if (flush) begin
                        fstate   <= F_REQ;
                        req_addr <= {addr[ADDR_SIZE-1:2], 2'b00};
                    end else if (target_known && room) begin
                        fstate   <= F_REQ;
                        req_addr <= {fetch_ptr[ADDR_SIZE-1:2], 2'b00};
                    end
                end
                F_REQ: begin
                    if (mem_ack) begin
                        fstate <= F_IDLE;
                    end else if (flush) begin
                        fstate <= F_DROP;
                    end
                end
                F_DROP: begin
                    if (mem_ack) begin
                        fstate <= F_IDLE;
                    end
                end
                default: fstate <= F_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sstate <= S_WAIT;
            qaddr  <= '0;
            mfc    <= 1'b0;
            data   <= 8'h00;
        end else begin
            case (sstate)
                S_WAIT: begin
                    if (flush) begin
                        qaddr <= addr;
                    end else if (serve) begin
                        data   <= serve_byte;
                        qaddr  <= qaddr + 1'b1;
                        mfc    <= 1'b1;
                        sstate <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (!strb) begin
                        mfc    <= 1'b0;
                        sstate <= S_WAIT;
                    end
                end
                default: sstate <= S_WAIT;
            endcase
        end
    end

`ifdef PREFETCH_QUEUE_STATS_EN
    logic flushed_req;

    // A request that had to flush is served later but does not count as a hit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hit_cnt     <= '0;
            flush_cnt   <= '0;
            flushed_req <= 1'b0;
        end else begin
            if (flush) begin
                flushed_req <= 1'b1;
                if (flush_cnt != 32'hFFFF_FFFF) begin
                    flush_cnt <= flush_cnt + 1'b1;
                end
            end else if (serve) begin
                flushed_req <= 1'b0;
                if (!flushed_req && (hit_cnt != 32'hFFFF_FFFF)) begin
                    hit_cnt <= hit_cnt + 1'b1;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_prefetch_queue.sv
// tb/tb_prefetch_queue.sv - directed self-checking bench for prefetch_queue
module tb_prefetch_queue;

    logic        clk = 1'b0;
    logic        reset;
    logic        strb;
    logic [31:0] addr;
    logic        mfc;
    logic [7:0]  data;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_data;
`ifdef PREFETCH_QUEUE_STATS_EN
    logic [31:0] hit_cnt;
    logic [31:0] flush_cnt;
`endif

    int tests = 0;
    int fails = 0;

    bit          resp_en;
    int          resp_lat;
    int          wait_cnt;
    logic        resp_ack;
    logic [31:0] resp_data;
    logic        man_ack;
    logic [31:0] man_data;

    assign mem_ack  = resp_ack | man_ack;
    assign mem_data = man_ack ? man_data : resp_data;

    always #5 clk = ~clk;

    prefetch_queue dut (
        .clk       (clk),
        .reset     (reset),
        .strb      (strb),
        .addr      (addr),
        .mfc       (mfc),
        .data      (data),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .mem_ack   (mem_ack),
        .mem_data  (mem_data)
`ifdef PREFETCH_QUEUE_STATS_EN
        ,
        .hit_cnt   (hit_cnt),
        .flush_cnt (flush_cnt)
`endif
    );

    // Memory contents: byte at address a is {n,n} with n = a[3:0]+1 (0x100 -> 0x11).
    function automatic logic [7:0] mbyte(input logic [31:0] a);
        logic [3:0] n;
        n = a[3:0] + 4'd1;
        return {n, n};
    endfunction

    function automatic logic [31:0] mword(input logic [31:0] a);
        logic [31:0] b;
        b = {a[31:2], 2'b00};
        return {mbyte(b + 32'd3), mbyte(b + 32'd2), mbyte(b + 32'd1), mbyte(b)};
    endfunction

    initial begin
        resp_ack  = 1'b0;
        resp_data = 32'h0;
        wait_cnt  = 0;
        forever begin
            @(posedge clk);
            #1;
            resp_ack = 1'b0;
            if (resp_en && mem_req && !reset) begin
                if (wait_cnt >= resp_lat) begin
                    resp_ack  = 1'b1;
                    resp_data = mword(mem_addr);
                    wait_cnt  = 0;
                end else begin
                    wait_cnt++;
                end
            end else begin
                wait_cnt = 0;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    task automatic do_reset();
        reset   = 1'b1;
        strb    = 1'b0;
        addr    = 32'h0;
        man_ack = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic strb_read(input logic [31:0] a, output logic [7:0] d, output int cyc,
                             output logic [31:0] first_ma, output logic [31:0] last_ma,
                             output logic mfc_after);
        bit seen;
        seen     = 1'b0;
        first_ma = 32'h0;
        last_ma  = 32'h0;
        cyc      = -1;
        strb     = 1'b1;
        addr     = a;
        for (int i = 1; i <= 200; i++) begin
            @(negedge clk);
            if (mem_req) begin
                if (!seen) first_ma = mem_addr;
                seen    = 1'b1;
                last_ma = mem_addr;
            end
            if (mfc) begin
                cyc = i;
                break;
            end
        end
        d = data;
        if (cyc < 0) begin
            tests++;
            fails++;
            $display("FAIL strb_timeout addr=%h: no mfc, required mfc within 200 cycles", a);
        end
        strb = 1'b0;
        @(negedge clk);
        mfc_after = mfc;
    endtask

    task automatic test_reset();
        @(negedge clk);
        tests++;
        if ({mfc, data, mem_req, mem_addr} !== 42'h0) begin
            fails++;
            $display("FAIL reset_outputs got mfc=%b data=%h mem_req=%b mem_addr=%h required all zero",
                     mfc, data, mem_req, mem_addr);
        end
        reset = 1'b0;
        repeat (6) @(negedge clk);
        tests++;
        if (mem_req !== 1'b0) begin
            fails++;
            $display("FAIL no_fetch_before_strb got mem_req=%b required 0", mem_req);
        end
    endtask

    task automatic test_basic();
        logic [7:0]  d;
        int          cyc;
        logic [31:0] fa, la;
        logic        ma;
        logic [7:0]  exp_d [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
        do_reset();
        resp_lat = 1;
        strb_read(32'h100, d, cyc, fa, la, ma);
        tests++;
        if (fa !== 32'h100) begin
            fails++;
            $display("FAIL basic_mem_addr got %h required 00000100", fa);
        end
        tests++;
        if (cyc !== 3) begin
            fails++;
            $display("FAIL basic_miss_latency got %0d required 3", cyc);
        end
        tests++;
        if (ma !== 1'b0) begin
            fails++;
            $display("FAIL basic_mfc_drop got %b required 0", ma);
        end
        for (int i = 0; i < 4; i++) begin
            if (i > 0) strb_read(32'h100 + 32'(i), d, cyc, fa, la, ma);
            tests++;
            if (d !== exp_d[i]) begin
                fails++;
                $display("FAIL basic_data[%0d] got %h required %h", i, d, exp_d[i]);
            end
            if (i > 0) begin
                tests++;
                if (cyc !== 1) begin
                    fails++;
                    $display("FAIL basic_hit_latency[%0d] got %0d required 1", i, cyc);
                end
            end
        end
`ifdef PREFETCH_QUEUE_STATS_EN
        tests++;
        if (hit_cnt !== 32'd3 || flush_cnt !== 32'd1) begin
            fails++;
            $display("FAIL basic_stats got hit=%0d flush=%0d required hit=3 flush=1", hit_cnt, flush_cnt);
        end
`endif
    endtask

    task automatic test_unaligned();
        logic [7:0]  d;
        int          cyc;
        logic [31:0] fa, la;
        logic        ma;
        do_reset();
        resp_lat = 1;
        strb_read(32'h103, d, cyc, fa, la, ma);
        tests++;
        if (fa !== 32'h100 || d !== 8'h44) begin
            fails++;
            $display("FAIL unaligned_first got mem_addr=%h data=%h required 00000100/44", fa, d);
        end
        for (int i = 0; i < 20 && !mem_req; i++) @(negedge clk);
        tests++;
        if (mem_req !== 1'b1 || mem_addr !== 32'h104) begin
            fails++;
            $display("FAIL unaligned_next_fetch got req=%b mem_addr=%h required 1/00000104", mem_req, mem_addr);
        end
        strb_read(32'h104, d, cyc, fa, la, ma);
        tests++;
        if (d !== 8'h55) begin
            fails++;
            $display("FAIL unaligned_next_byte got %h required 55", d);
        end
    endtask

    task automatic test_flush_during_req();
        logic [7:0]  d;
        int          cyc;
        logic [31:0] fa, la;
        logic        ma;
        bit          found;
        do_reset();
        resp_lat = 1;
        strb_read(32'h100, d, cyc, fa, la, ma);
        resp_lat = 8;
        for (int i = 1; i < 4; i++) strb_read(32'h100 + 32'(i), d, cyc, fa, la, ma);
        found = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (mem_req && mem_addr == 32'h108) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        tests++;
        if (!found) begin
            fails++;
            $display("FAIL flush_wait_108 got no request for 00000108 required one within 60 cycles");
        end
        strb_read(32'h200, d, cyc, fa, la, ma);
        tests++;
        if (fa !== 32'h108 || la !== 32'h200) begin
            fails++;
            $display("FAIL flush_addrs got first=%h last=%h required 00000108/00000200", fa, la);
        end
        tests++;
        if (d !== 8'h11) begin
            fails++;
            $display("FAIL flush_data got %h required 11", d);
        end
        strb_read(32'h201, d, cyc, fa, la, ma);
        tests++;
        if (d !== 8'h22 || cyc !== 1) begin
            fails++;
            $display("FAIL flush_next got data=%h lat=%0d required 22/1", d, cyc);
        end
        resp_lat = 1;
    endtask

    task automatic test_stall();
        logic [7:0]  d;
        int          cyc;
        logic [31:0] fa, la;
        logic        ma;
        bit          req_seen;
        logic [7:0]  exp_d [8] = '{8'h55, 8'h66, 8'h77, 8'h88, 8'h99, 8'hAA, 8'hBB, 8'hCC};
        do_reset();
        resp_lat = 1;
        strb_read(32'h103, d, cyc, fa, la, ma);
        repeat (20) @(negedge clk);
        tests++;
        if (dut.u_fifo.count !== 4'd8) begin
            fails++;
            $display("FAIL stall_count got %0d required 8", dut.u_fifo.count);
        end
        req_seen = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (mem_req) req_seen = 1'b1;
        end
        tests++;
        if (req_seen) begin
            fails++;
            $display("FAIL stall_no_req got mem_req=1 while full required 0");
        end
        for (int i = 0; i < 8; i++) begin
            strb_read(32'h104 + 32'(i), d, cyc, fa, la, ma);
            tests++;
            if (d !== exp_d[i] || cyc !== 1) begin
                fails++;
                $display("FAIL stall_data[%0d] got data=%h lat=%0d required %h/1", i, d, cyc, exp_d[i]);
            end
        end
    endtask

    task automatic test_hold();
        logic [7:0]  d;
        int          cyc;
        logic [31:0] fa, la;
        logic        ma;
        bit          got;
        do_reset();
        resp_lat = 1;
        strb_read(32'h100, d, cyc, fa, la, ma);
        strb = 1'b1;
        addr = 32'h101;
        got  = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (mfc) begin
                got = 1'b1;
                break;
            end
        end
        tests++;
        if (!got || data !== 8'h22) begin
            fails++;
            $display("FAIL hold_first got mfc=%b data=%h required 1/22", mfc, data);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            tests++;
            if (mfc !== 1'b1 || data !== 8'h22) begin
                fails++;
                $display("FAIL hold_stable[%0d] got mfc=%b data=%h required 1/22", i, mfc, data);
            end
        end
        strb = 1'b0;
        #1;
        tests++;
        if (mfc !== 1'b1) begin
            fails++;
            $display("FAIL hold_before_edge got mfc=%b required 1", mfc);
        end
        @(negedge clk);
        tests++;
        if (mfc !== 1'b0) begin
            fails++;
            $display("FAIL hold_release got mfc=%b required 0", mfc);
        end
    endtask

    task automatic test_reset_mid_req();
        logic [7:0]  d;
        int          cyc;
        logic [31:0] fa, la;
        logic        ma;
        do_reset();
        resp_en = 1'b0;
        strb    = 1'b1;
        addr    = 32'h300;
        for (int i = 0; i < 10 && !mem_req; i++) @(negedge clk);
        tests++;
        if (mem_req !== 1'b1) begin
            fails++;
            $display("FAIL rstmid_req_up got mem_req=%b required 1", mem_req);
        end
        reset = 1'b1;
        #1;
        tests++;
        if (mem_req !== 1'b0 || mem_addr !== 32'h0 || mfc !== 1'b0) begin
            fails++;
            $display("FAIL rstmid_async got req=%b addr=%h mfc=%b required 0/0/0", mem_req, mem_addr, mfc);
        end
        strb = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        man_ack  = 1'b1;
        man_data = 32'hDEADBEEF;
        @(negedge clk);
        man_ack = 1'b0;
        repeat (3) @(negedge clk);
        tests++;
        if (mem_req !== 1'b0 || dut.u_fifo.count !== 4'd0) begin
            fails++;
            $display("FAIL rstmid_stale_ack got req=%b count=%0d required 0/0", mem_req, dut.u_fifo.count);
        end
`ifdef PREFETCH_QUEUE_STATS_EN
        tests++;
        if (hit_cnt !== 32'd0 || flush_cnt !== 32'd0) begin
            fails++;
            $display("FAIL rstmid_stats got hit=%0d flush=%0d required 0/0", hit_cnt, flush_cnt);
        end
`endif
        resp_en = 1'b1;
        strb_read(32'h300, d, cyc, fa, la, ma);
        tests++;
        if (d !== 8'h11) begin
            fails++;
            $display("FAIL rstmid_after got %h required 11", d);
        end
    endtask

    initial begin
        reset    = 1'b1;
        strb     = 1'b0;
        addr     = 32'h0;
        man_ack  = 1'b0;
        man_data = 32'h0;
        resp_en  = 1'b1;
        resp_lat = 1;
        test_reset();
        test_basic();
        test_unaligned();
        test_flush_during_req();
        test_stall();
        test_hold();
        test_reset_mid_req();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
